// File: rtl/load_updown_counter.sv
//==============================================================================
// Module      : load_updown_counter
// Description : Loadable up/down counter with a runtime modulus, a choice of
//               wrap or saturate at the bounds, a registered bound pulse and a
//               sticky overflow flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_updown_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] count_out,
    output logic             wrap_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic             w_at_top;
    logic             w_at_zero;
    logic             w_bound;
    logic [WIDTH-1:0] w_up_bound_val;
    logic [WIDTH-1:0] w_dn_bound_val;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;

    // ">=" rather than "==" so a limit lowered beneath the count still
    // produces a bound event on the next up step.
    assign w_at_top  = (r_count >= limit_i);
    assign w_at_zero = (r_count == c_ZERO);
    assign w_bound   = up_i ? w_at_top : w_at_zero;

    assign w_load_val = (load_val_i > limit_i) ? limit_i : load_val_i;

    generate
        if (SATURATE) begin : g_saturate
            assign w_up_bound_val = limit_i;
            assign w_dn_bound_val = c_ZERO;
        end else begin : g_wrap
            assign w_up_bound_val = c_ZERO;
            assign w_dn_bound_val = limit_i;
        end
    endgenerate

    always_comb begin
        w_step_val = r_count;
        if (up_i) begin
            w_step_val = w_at_top ? w_up_bound_val : (r_count + c_ONE);
        end else begin
            w_step_val = w_at_zero ? w_dn_bound_val : (r_count - c_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= c_ZERO;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load_i) begin
            r_count <= w_load_val;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wrap <= en_i & w_bound;
            if (en_i) begin
                r_count <= w_step_val;
            end
            // A bound event on this edge beats a simultaneous clear.
            if (en_i && w_bound) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count_out = r_count;
    assign wrap_o    = r_wrap;
    assign ovf_o     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_load_updown_counter.sv
//==============================================================================
// Module      : tb_load_updown_counter
// Description : Directed bench for load_updown_counter, WIDTH=4, driving one
//               wrapping and one saturating instance from shared inputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_updown_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en_i;
    logic             up_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] limit_i;
    logic             clr_ovf_i;

    logic [WIDTH-1:0] cnt_w, cnt_s;
    logic             wrap_w, wrap_s, ovf_w, ovf_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_updown_counter #(.WIDTH(WIDTH), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en_i(en_i), .up_i(up_i), .load_i(load_i),
        .load_val_i(load_val_i), .limit_i(limit_i), .clr_ovf_i(clr_ovf_i),
        .count_out(cnt_w), .wrap_o(wrap_w), .ovf_o(ovf_w)
    );

    load_updown_counter #(.WIDTH(WIDTH), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en_i(en_i), .up_i(up_i), .load_i(load_i),
        .load_val_i(load_val_i), .limit_i(limit_i), .clr_ovf_i(clr_ovf_i),
        .count_out(cnt_s), .wrap_o(wrap_s), .ovf_o(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of control and wait past the edge.
    task automatic drive(input logic l, input logic e, input logic u,
                         input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] lim,
                         input logic c);
        load_i = l; en_i = e; up_i = u; load_val_i = lv; limit_i = lim; clr_ovf_i = c;
        step();
    endtask

    initial begin
        int exp_cnt [7];
        exp_cnt = '{10, 11, 12, 13, 14, 15, 0};

        // Reset with load and enable both asserted
        reset = 1'b1; en_i = 1'b1; up_i = 1'b1; load_i = 1'b1;
        load_val_i = 4'd5; limit_i = 4'd15; clr_ovf_i = 1'b0;
        step(); step();
        chk("rst_cnt_w", cnt_w, 0);  chk("rst_wrap_w", wrap_w, 0); chk("rst_ovf_w", ovf_w, 0);
        chk("rst_cnt_s", cnt_s, 0);  chk("rst_wrap_s", wrap_s, 0); chk("rst_ovf_s", ovf_s, 0);
        reset = 1'b0;

        // Load 9, count up through the wrap
        drive(1, 0, 1, 4'd9, 4'd15, 0);
        chk("ld9_cnt", cnt_w, 9); chk("ld9_ovf", ovf_w, 0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 1, 4'd0, 4'd15, 0);
            chk($sformatf("up_cnt%0d", i), cnt_w, exp_cnt[i]);
            chk($sformatf("up_wrap%0d", i), wrap_w, (i == 6) ? 1 : 0);
        end
        chk("up_ovf", ovf_w, 1);
        drive(0, 0, 1, 4'd0, 4'd15, 0);
        chk("hold_cnt", cnt_w, 0); chk("hold_wrap", wrap_w, 0); chk("hold_ovf", ovf_w, 1);

        // Down wrap with modulus 5
        drive(1, 0, 0, 4'd1, 4'd5, 0);
        chk("ld1_cnt", cnt_w, 1); chk("ld1_ovf_clr", ovf_w, 0);
        drive(0, 1, 0, 4'd0, 4'd5, 0);
        chk("dn_cnt0", cnt_w, 0); chk("dn_wrap0", wrap_w, 0);
        drive(0, 1, 0, 4'd0, 4'd5, 0);
        chk("dn_cnt1", cnt_w, 5); chk("dn_wrap1", wrap_w, 1);
        drive(0, 1, 0, 4'd0, 4'd5, 0);
        chk("dn_cnt2", cnt_w, 4); chk("dn_wrap2", wrap_w, 0); chk("dn_ovf", ovf_w, 1);

        // Saturating instance
        drive(1, 0, 1, 4'd14, 4'd15, 0);
        chk("sat_ld", cnt_s, 14);
        drive(0, 1, 1, 4'd0, 4'd15, 0);
        chk("sat_cnt0", cnt_s, 15); chk("sat_wrap0", wrap_s, 0);
        drive(0, 1, 1, 4'd0, 4'd15, 0);
        chk("sat_cnt1", cnt_s, 15); chk("sat_wrap1", wrap_s, 1);
        drive(0, 1, 1, 4'd0, 4'd15, 0);
        chk("sat_cnt2", cnt_s, 15); chk("sat_wrap2", wrap_s, 1); chk("sat_ovf", ovf_s, 1);
        drive(1, 0, 0, 4'd0, 4'd15, 0);
        drive(0, 1, 0, 4'd0, 4'd15, 0);
        chk("sat_dn_cnt", cnt_s, 0); chk("sat_dn_wrap", wrap_s, 1);
        chk("wrp_dn_cnt", cnt_w, 15); chk("wrp_dn_wrap", wrap_w, 1);

        // Load clamp, then a lowered limit
        drive(1, 0, 1, 4'd12, 4'd7, 0);
        chk("clamp_w", cnt_w, 7); chk("clamp_s", cnt_s, 7);
        drive(0, 1, 1, 4'd0, 4'd3, 0);
        chk("live_up_w", cnt_w, 0); chk("live_wrap_w", wrap_w, 1);
        chk("live_up_s", cnt_s, 3); chk("live_wrap_s", wrap_s, 1);
        drive(1, 0, 0, 4'd10, 4'd15, 0);
        drive(0, 1, 0, 4'd0, 4'd3, 0);
        chk("live_dn_cnt", cnt_w, 9); chk("live_dn_wrap", wrap_w, 0);

        // Zero limit pins the count
        drive(1, 0, 1, 4'd9, 4'd0, 0);
        chk("lim0_ld", cnt_w, 0);
        drive(0, 1, 1, 4'd0, 4'd0, 0);
        chk("lim0_up_cnt", cnt_w, 0); chk("lim0_up_wrap", wrap_w, 1);
        drive(0, 1, 0, 4'd0, 4'd0, 0);
        chk("lim0_dn_cnt", cnt_w, 0); chk("lim0_dn_wrap", wrap_w, 1);
        chk("lim0_dn_cnt_s", cnt_s, 0);

        // Load beats enable; set beats clear; clear alone
        drive(1, 1, 1, 4'd4, 4'd15, 0);
        chk("ld_en_cnt", cnt_w, 4); chk("ld_en_ovf", ovf_w, 0); chk("ld_en_wrap", wrap_w, 0);
        drive(1, 0, 1, 4'd15, 4'd15, 0);
        drive(0, 1, 1, 4'd0, 4'd15, 1);
        chk("setclr_cnt", cnt_w, 0); chk("setclr_wrap", wrap_w, 1); chk("setclr_ovf", ovf_w, 1);
        drive(0, 0, 1, 4'd0, 4'd15, 1);
        chk("clr_ovf", ovf_w, 0); chk("clr_cnt", cnt_w, 0); chk("clr_wrap", wrap_w, 0);

        // Reset mid-count, then resume from zero
        drive(0, 1, 1, 4'd0, 4'd15, 0);
        drive(0, 1, 1, 4'd0, 4'd15, 0);
        chk("pre_rst_cnt", cnt_w, 2);
        reset = 1'b1;
        drive(1, 1, 1, 4'd9, 4'd15, 0);
        chk("mid_rst_cnt", cnt_w, 0);
        reset = 1'b0;
        drive(0, 1, 1, 4'd0, 4'd15, 0);
        chk("resume_cnt", cnt_w, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
